toggle_req_receiver: RTL and testbench

//  Receive end of the toggle-level request/ack handshake whose transmit side is a toggle

---
 rtl/toggle_req_receiver.sv | 133 +++++++++++++
 tb/tb_toggle_req_receiver.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_req_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : toggle_req_receiver
//  Purpose  : Receive side of a toggle-level request/ack clock-domain crossing.
//             A flip of req_tgl (from a toggle flop in a foreign domain)
//             announces a new word on req_data. The toggle is synchronized,
//             the word is captured and offered on a valid/ready port, and
//             ack_tgl flips once the consumer takes the word.
//  Ports    : clk        - receive-domain clock, rising edge
//             preset     - asynchronous active-high reset
//             req_tgl    - request toggle (asynchronous to clk)
//             req_data   - payload, stable from req_tgl flip to ack_tgl flip
//             out_valid  - out_data holds an unconsumed word
//             out_data   - captured word (kept after consumption)
//             out_ready  - consumer accepts when out_valid & out_ready
//             ack_tgl    - flips once per consumed word
//             busy       - high while a word is held
//             overrun    - sticky: req_tgl flipped again before the ack
//  Revision : 1.0  initial release
// ============================================================================
module toggle_req_receiver #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2   // legal range 2..4
) (
    input  logic              clk,
    input  logic              preset,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] req_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              ack_tgl,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_exp_lvl;
    logic                   r_out_valid;
    logic [DATA_W-1:0]      r_out_data;
    logic                   r_ack_tgl;
    logic                   r_overrun;

    logic                   w_req_s;
    logic                   w_pending;
    logic                   w_capture;
    logic                   w_accept;
    logic                   w_overrun_set;

    // Synchronizer chain for the request toggle; req_data is deliberately not
    // synchronized because the protocol holds it stable across the crossing.
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], req_tgl};
        end
    end

    assign w_req_s   = r_sync[SYNC_STAGES-1];
    // Level compare against the expected toggle level: a flip that arrives
    // while a word is held stays visible and is served later.
    assign w_pending = (w_req_s != r_exp_lvl);

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_accept      = 1'b0;
        w_overrun_set = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pending) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_overrun_set = w_pending;
                if (out_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            r_exp_lvl   <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_ack_tgl   <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_capture) begin
                r_out_data  <= req_data;
                r_out_valid <= 1'b1;
                r_exp_lvl   <= ~r_exp_lvl;
            end
            if (w_accept) begin
                r_out_valid <= 1'b0;
                r_ack_tgl   <= ~r_ack_tgl;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign ack_tgl   = r_ack_tgl;
    assign busy      = (r_state == ST_HOLD);
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_toggle_req_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_toggle_req_receiver
//  Purpose  : Self-checking bench for toggle_req_receiver. Words are pushed
//             to a scoreboard queue when a request is issued and compared
//             in order when the consumer accepts them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_toggle_req_receiver;

    logic       clk;
    logic       preset;
    logic       req_tgl;
    logic [7:0] req_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic       ack_tgl;
    logic       busy;
    logic       overrun;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] sb[$];

    typedef struct {
        logic [7:0] data;
        logic       exp_ack;
    } vec_t;

    vec_t vecs[4];

    toggle_req_receiver #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .preset    (preset),
        .req_tgl   (req_tgl),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ack_tgl   (ack_tgl),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        req_data = d;
        req_tgl  = ~req_tgl;
        sb.push_back(d);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"},   out_valid, 0);
        check({name, "_data"},    out_data,  0);
        check({name, "_ack"},     ack_tgl,   0);
        check({name, "_busy"},    busy,      0);
        check({name, "_overrun"}, overrun,   0);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) check({name, "_timeout"}, out_valid, 1);
    endtask

    task automatic wait_ack(input string name, input logic exp);
        int n;
        n = 0;
        while (ack_tgl !== exp && n < 30) begin
            tick();
            n++;
        end
        check(name, ack_tgl, exp);
    endtask

    // Scoreboard: an accept happens at the next rising edge whenever
    // out_valid & out_ready are seen here.
    always @(negedge clk) begin
        if (!preset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_word", out_data, 32'hFFFF_FFFF);
            end else begin
                check("sb_word", out_data, sb.pop_front());
            end
        end
    end

    initial begin
        vecs[0] = '{data: 8'h01, exp_ack: 1'b1};
        vecs[1] = '{data: 8'h02, exp_ack: 1'b0};
        vecs[2] = '{data: 8'h03, exp_ack: 1'b1};
        vecs[3] = '{data: 8'h04, exp_ack: 1'b0};

        preset    = 1'b1;
        req_tgl   = 1'b0;
        req_data  = 8'h00;
        out_ready = 1'b0;

        // Reset state before any clock edge
        #2;
        check_all_zero("rst_initial");
        tick();
        tick();
        preset = 1'b0;
        tick();

        // Single word: capture after SYNC_STAGES+1 edges
        send(8'hA5);
        tick();
        check("single_lat_e1", out_valid, 0);
        tick();
        check("single_lat_e2", out_valid, 0);
        tick();
        check("single_lat_e3", out_valid, 1);
        check("single_data",   out_data,  8'hA5);
        check("single_busy",   busy,      1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_acc_valid", out_valid, 0);
        check("single_acc_ack",   ack_tgl,   1);
        check("single_acc_busy",  busy,      0);

        // Backpressure: hold for 20 cycles
        send(8'hA5);
        wait_valid("bp_valid");
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data",  out_data,  8'hA5);
            check("bp_hold_ack",   ack_tgl,   1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_ack_flip", ack_tgl, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_ack_once", ack_tgl, 0);
        end

        // Stream with out_ready tied high
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data);
            wait_ack("stream_ack", vecs[i].exp_ack);
        end
        tick();
        check("stream_overrun", overrun, 0);
        check("stream_sb_empty", sb.size(), 0);
        out_ready = 1'b0;

        // Overrun: second flip before ack
        send(8'h11);
        wait_valid("ovr_first_valid");
        send(8'h22);
        for (int i = 0; i < 4; i++) tick();
        check("ovr_set",        overrun,  1);
        check("ovr_hold_data",  out_data, 8'h11);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ovr_acc1_ack", ack_tgl, 1);
        wait_valid("ovr_second_valid");
        check("ovr_second_data", out_data, 8'h22);
        check("ovr_sticky1",     overrun,  1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("ovr_acc2_ack", ack_tgl, 0);
        for (int i = 0; i < 3; i++) tick();
        check("ovr_sticky2", overrun,   1);
        check("ovr_no_extra", out_valid, 0);

        // Reset mid-HOLD: asynchronous, no edge needed
        send(8'h33);
        wait_valid("midrst_valid");
        preset  = 1'b1;
        req_tgl = 1'b0;
        #2;
        check_all_zero("rst_mid");
        sb.delete();
        tick();
        tick();
        preset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_idle_valid", out_valid, 0);
        end

        // Reset release with req_tgl already high: exactly one capture
        preset = 1'b1;
        tick();
        req_tgl  = 1'b1;
        req_data = 8'h5A;
        sb.push_back(8'h5A);
        tick();
        preset = 1'b0;
        tick();
        check("relhi_e1", out_valid, 0);
        tick();
        check("relhi_e2", out_valid, 0);
        tick();
        check("relhi_e3",   out_valid, 1);
        check("relhi_data", out_data,  8'h5A);
        out_ready = 1'b1;
        tick();
        check("relhi_ack", ack_tgl, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("relhi_once", out_valid, 0);
        end
        out_ready = 1'b0;
        check("relhi_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
